// File: rtl/display_pkg.sv
// Shared types, constants and the seven-segment encoder for the result display.
package display_pkg;

  localparam int         RESULT_W   = 4;
  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'b111_1111;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam logic [7:0] COUNT_MAX  = 8'd255;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; codes above 9 are "no class".
  function automatic logic [6:0] seg_encode(input logic [RESULT_W-1:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b100_0000;
      4'd1:    seg = 7'b111_1001;
      4'd2:    seg = 7'b010_0100;
      4'd3:    seg = 7'b011_0000;
      4'd4:    seg = 7'b001_1001;
      4'd5:    seg = 7'b001_0010;
      4'd6:    seg = 7'b000_0010;
      4'd7:    seg = 7'b111_1000;
      4'd8:    seg = 7'b000_0000;
      4'd9:    seg = 7'b001_0000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic is_digit(input logic [RESULT_W-1:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/result_display_mux_if.sv
// Result capture inputs and seven-segment display outputs of the result display.
interface result_display_mux_if;
  import display_pkg::*;

  logic                result_ready;
  logic [RESULT_W-1:0] result_in;
  logic                clear;
  logic [6:0]          seg;
  logic                dp;
  logic [3:0]          an;
  logic [7:0]          result_count;

  modport master (
    output result_ready, result_in, clear,
    input  seg, dp, an, result_count
  );

  modport slave (
    input  result_ready, result_in, clear,
    output seg, dp, an, result_count
  );

endinterface

// File: rtl/scan_timer.sv
// Digit-slot prescaler: advance pulses once per REFRESH_DIV cycles and steps digit_sel.
module scan_timer #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] digit_sel_o,
  output logic       advance_o
);

  localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;

  assign advance_o   = (cnt_q == CNT_LAST);
  assign digit_sel_o = sel_q;

  // Wrap the prescaler on terminal count and move to the next digit slot.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (advance_o) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      sel_d = sel_q;
    end
  end

  // Prescaler and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/result_display_mux.sv
// Four-deep BNN result history shown on a multiplexed 4-digit seven-segment display,
// newest result on digit 0 with its decimal point lit.
module result_display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  result_display_mux_if.slave   bus
);

  logic [NUM_DIGITS-1:0][RESULT_W-1:0] hist_q, hist_d;
  logic [NUM_DIGITS-1:0]               hv_q, hv_d;
  logic [7:0]                          count_q, count_d;
  scan_state_t                         state_q, state_d;
  logic [6:0]                          seg_q, seg_d;
  logic                                dp_q, dp_d;
  logic [3:0]                          an_q, an_d;

  logic [1:0]          digit_sel;
  logic                advance;
  logic [RESULT_W-1:0] sel_code;
  logic                sel_lit;

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_sel_o (digit_sel),
    .advance_o   (advance)
  );

  // History shift and saturating capture count; clear beats a coincident capture.
  always_comb begin
    hist_d  = hist_q;
    hv_d    = hv_q;
    count_d = count_q;
    if (bus.clear) begin
      hv_d    = '0;
      count_d = 8'd0;
    end else if (bus.result_ready) begin
      hist_d = {hist_q[NUM_DIGITS-2:0], bus.result_in};
      hv_d   = {hv_q[NUM_DIGITS-2:0], 1'b1};
      if (count_q != COUNT_MAX) begin
        count_d = count_q + 8'd1;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // One BLANK cycle follows every slot change to suppress ghosting.
  always_comb begin
    state_d = SCAN;
    if (advance) begin
      state_d = BLANK;
    end else begin
      state_d = SCAN;
    end
  end

  assign sel_code = hist_q[digit_sel];
  assign sel_lit  = hv_q[digit_sel] && is_digit(sel_code);

  // Next display value; empty or no-class slots keep their anode driven but stay dark.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    case (state_q)
      SCAN: begin
        an_d = ~(4'b0001 << digit_sel);
        if (sel_lit) begin
          seg_d = seg_encode(sel_code);
          dp_d  = (digit_sel != 2'd0);
        end else begin
          seg_d = SEG_BLANK;
          dp_d  = 1'b1;
        end
      end
      BLANK: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end
    endcase
  end

  // State, history and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      hist_q  <= '0;
      hv_q    <= '0;
      count_q <= 8'd0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      hv_q    <= hv_d;
      count_q <= count_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign bus.seg          = seg_q;
  assign bus.dp           = dp_q;
  assign bus.an           = an_q;
  assign bus.result_count = count_q;

endmodule

// File: tb/tb_result_display_mux.sv
// Scoreboard bench for result_display_mux with REFRESH_DIV=4: stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_result_display_mux;
  import display_pkg::*;

  localparam int DIV = 4;

  logic clk;
  logic rst_n;

  result_display_mux_if bus();

  result_display_mux #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         stamp;
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       chk_seg;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   base     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: compare every expectation stamped for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.stamp < cyc) begin
        n_checks++;
        $display("FAIL %s/missed: sampled at cycle %0d, required cycle %0d", mon_e.name, cyc, mon_e.stamp);
      end else begin
        check({mon_e.name, "/an"}, int'(bus.an), int'(mon_e.an));
        check({mon_e.name, "/count"}, int'(bus.result_count), int'(mon_e.cnt));
        if (mon_e.chk_seg) begin
          check({mon_e.name, "/seg"}, int'(bus.seg), int'(mon_e.seg));
          check({mon_e.name, "/dp"}, int'(bus.dp), int'(mon_e.dp));
        end
      end
    end
  end

  task automatic push(input string name, input int stamp, input logic [3:0] an,
                      input logic [6:0] seg, input logic dp, input logic chk_seg,
                      input logic [7:0] cnt);
    exp_t e;
    e.stamp = stamp; e.name = name; e.an = an; e.seg = seg;
    e.dp = dp; e.chk_seg = chk_seg; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Scan position k (cycles since reset release): slot k-1 div 4, first cycle of each slot blank.
  task automatic push_k(input string name, input int k, input logic [6:0] seg,
                        input logic dp, input logic [7:0] cnt);
    int         p;
    int         d;
    logic [3:0] an_v;
    p = (k - 1) % 4;
    d = ((k - 1) / 4) % 4;
    an_v = ~(4'b0001 << d);
    if (p == 0) push(name, base + k, 4'b1111, SEG_BLANK, 1'b1, 1'b0, cnt);
    else        push(name, base + k, an_v, seg, dp, 1'b1, cnt);
  endtask

  // Expect one full scan (all four slots and their blank cycles) starting at position start_k.
  task automatic check_frame(input string name, input int start_k,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic dp0, input logic [7:0] cnt);
    logic [6:0] s [4];
    int         d;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int kk = start_k; kk < start_k + 16; kk++) begin
      d = ((kk - 1) / 4) % 4;
      push_k(name, kk, s[d], (d == 0) ? dp0 : 1'b1, cnt);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    bus.result_ready = 1'b0;
    bus.result_in    = 4'd0;
    bus.clear        = 1'b0;

    // Reset held for 5 cycles, then one dark scan.
    @(negedge clk);
    push("reset_hold", 3, 4'b1111, SEG_BLANK, 1'b1, 1'b1, 8'd0);
    while (cyc < 5) @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    check_frame("reset_scan", 1, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, 1'b1, 8'd0);
    drain();

    // Single 7 captured while digit 0 is lit: count after 1 cycle, segments after 2.
    while ((cyc - base) % 16 != 2) @(negedge clk);
    k = cyc - base;
    bus.result_ready = 1'b1;
    bus.result_in    = 4'd7;
    push_k("single_lat1", k + 1, SEG_BLANK, 1'b1, 8'd1);
    push_k("single_lat2", k + 2, 7'b111_1000, 1'b0, 8'd1);
    @(negedge clk);
    bus.result_ready = 1'b0;
    check_frame("single", cyc - base + 2, 7'b111_1000, SEG_BLANK, SEG_BLANK, SEG_BLANK, 1'b0, 8'd1);
    drain();

    // Clear, then 1..5 back to back.
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      bus.result_ready = 1'b1;
      bus.result_in    = 4'(v);
      @(negedge clk);
    end
    bus.result_ready = 1'b0;
    check_frame("shift", cyc - base + 2, 7'b001_0010, 7'b001_1001, 7'b011_0000, 7'b010_0100, 1'b0, 8'd5);
    drain();

    // No-class code 10 takes digit 0 but stays dark.
    bus.result_ready = 1'b1;
    bus.result_in    = 4'd10;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check_frame("invalid", cyc - base + 2, SEG_BLANK, 7'b001_0010, 7'b001_1001, 7'b011_0000, 1'b1, 8'd6);
    drain();

    // Clear held with 9s arriving: every 9 is dropped.
    for (int i = 0; i < 3; i++) begin
      bus.clear        = 1'b1;
      bus.result_ready = 1'b1;
      bus.result_in    = 4'd9;
      @(negedge clk);
    end
    bus.clear        = 1'b0;
    bus.result_ready = 1'b0;
    check_frame("clear_collide", cyc - base + 2, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, 1'b1, 8'd0);
    drain();

    // 300 captures (i mod 10): count saturates, last four are 9,8,7,6.
    for (int i = 0; i < 300; i++) begin
      bus.result_ready = 1'b1;
      bus.result_in    = 4'(i % 10);
      @(negedge clk);
    end
    bus.result_ready = 1'b0;
    check_frame("saturate", cyc - base + 2, 7'b001_0000, 7'b000_0000, 7'b111_1000, 7'b000_0010, 1'b0, 8'd255);
    drain();

    // Asynchronous reset between edges takes effect before the next clock.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push("async_reset", cyc, 4'b1111, SEG_BLANK, 1'b1, 1'b1, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    check_frame("post_reset", 1, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, 1'b1, 8'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
